// File: rtl/eth_tx_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// eth_tx_pkg
// Shared definitions for the two-source Ethernet TX frame scheduler:
//   - tx_state_e       : scheduler state encoding (IDLE/CTRL/DATA/DROP)
//   - CTRL_FLAG_NORMAL : control word 0 for a normal transmit (Flag 0xA)
//   - CTRL_WORDS       : length of the MAC TX control frame in 32-bit words
//   - MAX_FRAME_WORDS  : longest data frame forwarded before truncation
//   - WCNT_W           : width of the per-frame data beat counter
//   - ctrl_word()      : builds one control-frame word from its index
// ---------------------------------------------------------------------------
package eth_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CTRL = 2'd1,
    ST_DATA = 2'd2,
    ST_DROP = 2'd3
  } tx_state_e;

  localparam logic [31:0] CTRL_FLAG_NORMAL = 32'hA000_0000;
  localparam int          CTRL_WORDS       = 6;
  localparam int          MAX_FRAME_WORDS  = 379;
  localparam int          WCNT_W           = 9;

  // Only word 0 of the control frame carries the flag; the rest are zero.
  function automatic logic [31:0] ctrl_word(input logic [31:0] flag,
                                            input logic        is_first);
    logic [31:0] w;
    if (is_first) begin
      w = flag;
    end else begin
      w = 32'h0000_0000;
    end
    return w;
  endfunction

endpackage

// File: rtl/eth_tx_arbiter_if.sv
// ---------------------------------------------------------------------------
// eth_tx_arbiter_if
// One 32-bit AXI-Stream link (data, byte keep, valid, last, ready).
// Modports:
//   master : drives tdata/tkeep/tvalid/tlast, receives tready
//   slave  : receives tdata/tkeep/tvalid/tlast, drives tready
// ---------------------------------------------------------------------------
interface eth_tx_arbiter_if;

  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tvalid;
  logic        tlast;
  logic        tready;

  modport master (
    output tdata,
    output tkeep,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tkeep,
    input  tvalid,
    input  tlast,
    output tready
  );

endinterface

// File: rtl/eth_tx_rr_arb.sv
// ---------------------------------------------------------------------------
// eth_tx_rr_arb
// Combinational two-way round-robin grant. When both ports request, the port
// that was not served last wins; a single requester always wins.
// Ports:
//   req[1:0]   in  : request per port
//   last_grant in  : port served most recently
//   gnt_valid  out : at least one request present
//   gnt_idx    out : winning port index (meaningful only with gnt_valid)
// The result is not registered here; the parent latches it.
// ---------------------------------------------------------------------------
module eth_tx_rr_arb (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  // Pick the winner from the request pattern and the previous grant.
  always_comb begin
    gnt_valid = |req;
    case (req)
      2'b01:   gnt_idx = 1'b0;
      2'b10:   gnt_idx = 1'b1;
      2'b11:   gnt_idx = ~last_grant;
      default: gnt_idx = 1'b0;
    endcase
  end

endmodule

// File: rtl/eth_tx_arbiter.sv
// ---------------------------------------------------------------------------
// eth_tx_arbiter
// Frame-level scheduler sharing one AXI Ethernet TX port (control + data
// streams) between two 32-bit AXI-Stream frame sources. Each granted frame is
// preceded by a CTRL_WORDS-long control frame on txc, then the source's data
// frame is passed through combinationally on txd up to its tlast. A frame
// longer than MAX_FRAME_WORDS is cut: the last allowed beat is sent with
// tlast forced, and the rest of the source frame is absorbed silently.
// Ports:
//   axis_clk, axis_aresetn   : clock, asynchronous active-low reset
//   enable                   : permits new grants (running frame completes)
//   s0, s1   (slave)         : frame sources
//   txd      (master)        : to MAC data stream
//   txc      (master)        : to MAC control stream
//   busy                     : scheduler not idle
//   grant                    : current / most recently granted port
//   oversize_err             : one-cycle pulse when a frame was truncated
//   frame_cnt0, frame_cnt1   : completed (non-truncated) frames per port
// ---------------------------------------------------------------------------
module eth_tx_arbiter
  import eth_tx_pkg::*;
#(
  parameter int          CTRL_WORDS_P      = CTRL_WORDS,
  parameter logic [31:0] CTRL_FLAG         = CTRL_FLAG_NORMAL,
  parameter int          MAX_FRAME_WORDS_P = MAX_FRAME_WORDS,
  parameter int          CNT_W             = 16
) (
  input  logic                 axis_clk,
  input  logic                 axis_aresetn,
  input  logic                 enable,
  eth_tx_arbiter_if.slave      s0,
  eth_tx_arbiter_if.slave      s1,
  eth_tx_arbiter_if.master     txd,
  eth_tx_arbiter_if.master     txc,
  output logic                 busy,
  output logic                 grant,
  output logic                 oversize_err,
  output logic [CNT_W-1:0]     frame_cnt0,
  output logic [CNT_W-1:0]     frame_cnt1
);

  localparam int                IDX_W     = (CTRL_WORDS_P > 1) ? $clog2(CTRL_WORDS_P) : 1;
  localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(CTRL_WORDS_P - 1);
  localparam logic [WCNT_W-1:0] WCNT_ONE  = WCNT_W'(1);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MAX_FRAME_WORDS_P - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  tx_state_e         state_r;
  tx_state_e         state_s;
  logic              grant_r;
  logic              last_grant_r;
  logic [IDX_W-1:0]  idx_r;
  logic [WCNT_W-1:0] wcnt_r;
  logic [CNT_W-1:0]  frame_cnt0_r;
  logic [CNT_W-1:0]  frame_cnt1_r;
  logic              oversize_err_r;

  logic              gnt_valid_s;
  logic              gnt_idx_s;
  logic              grant_take_s;

  logic [31:0]       src_tdata_s;
  logic [3:0]        src_tkeep_s;
  logic              src_tvalid_s;
  logic              src_tlast_s;

  logic              ctrl_beat_s;
  logic              ctrl_done_s;
  logic              data_beat_s;
  logic              frame_end_s;
  logic              trunc_s;
  logic              drop_beat_s;
  logic              drop_end_s;
  logic              at_limit_s;

  eth_tx_rr_arb u_rr_arb (
    .req        ({s1.tvalid, s0.tvalid}),
    .last_grant (last_grant_r),
    .gnt_valid  (gnt_valid_s),
    .gnt_idx    (gnt_idx_s)
  );

  // Select the granted source for pass-through and for frame tracking.
  always_comb begin
    if (grant_r) begin
      src_tdata_s  = s1.tdata;
      src_tkeep_s  = s1.tkeep;
      src_tvalid_s = s1.tvalid;
      src_tlast_s  = s1.tlast;
    end else begin
      src_tdata_s  = s0.tdata;
      src_tkeep_s  = s0.tkeep;
      src_tvalid_s = s0.tvalid;
      src_tlast_s  = s0.tlast;
    end
  end

  // Handshake qualifiers for every state.
  always_comb begin
    grant_take_s = (state_r == ST_IDLE) && enable && gnt_valid_s;
    ctrl_beat_s  = (state_r == ST_CTRL) && txc.tready;
    ctrl_done_s  = ctrl_beat_s && (idx_r == IDX_LAST);
    at_limit_s   = (wcnt_r == WCNT_LAST);
    data_beat_s  = (state_r == ST_DATA) && src_tvalid_s && txd.tready;
    frame_end_s  = data_beat_s && src_tlast_s;
    // A source tlast on the limit beat is a legal full-size frame, not a cut.
    trunc_s      = data_beat_s && !src_tlast_s && at_limit_s;
    drop_beat_s  = (state_r == ST_DROP) && src_tvalid_s;
    drop_end_s   = drop_beat_s && src_tlast_s;
  end

  // State register.
  always_ff @(posedge axis_clk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decision.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_take_s) begin
          state_s = ST_CTRL;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CTRL: begin
        if (ctrl_done_s) begin
          state_s = ST_DATA;
        end else begin
          state_s = ST_CTRL;
        end
      end
      ST_DATA: begin
        if (frame_end_s) begin
          state_s = ST_IDLE;
        end else if (trunc_s) begin
          state_s = ST_DROP;
        end else begin
          state_s = ST_DATA;
        end
      end
      ST_DROP: begin
        if (drop_end_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DROP;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Stream outputs per state; txc and txd are never driven valid together.
  always_comb begin
    txc.tdata  = 32'h0000_0000;
    txc.tkeep  = 4'h0;
    txc.tvalid = 1'b0;
    txc.tlast  = 1'b0;
    txd.tdata  = 32'h0000_0000;
    txd.tkeep  = 4'h0;
    txd.tvalid = 1'b0;
    txd.tlast  = 1'b0;
    s0.tready  = 1'b0;
    s1.tready  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        txc.tvalid = 1'b0;
      end
      ST_CTRL: begin
        txc.tvalid = 1'b1;
        txc.tkeep  = 4'hF;
        txc.tdata  = ctrl_word(CTRL_FLAG, idx_r == {IDX_W{1'b0}});
        txc.tlast  = (idx_r == IDX_LAST);
      end
      ST_DATA: begin
        txd.tvalid = src_tvalid_s;
        txd.tdata  = src_tdata_s;
        txd.tkeep  = src_tkeep_s;
        txd.tlast  = src_tlast_s || at_limit_s;
        if (grant_r) begin
          s1.tready = txd.tready;
        end else begin
          s0.tready = txd.tready;
        end
      end
      ST_DROP: begin
        if (grant_r) begin
          s1.tready = 1'b1;
        end else begin
          s0.tready = 1'b1;
        end
      end
      default: begin
        txc.tvalid = 1'b0;
      end
    endcase
  end

  // Grant, beat indices, frame counters and truncation pulse.
  always_ff @(posedge axis_clk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      grant_r        <= 1'b0;
      last_grant_r   <= 1'b1;
      idx_r          <= {IDX_W{1'b0}};
      wcnt_r         <= {WCNT_W{1'b0}};
      frame_cnt0_r   <= {CNT_W{1'b0}};
      frame_cnt1_r   <= {CNT_W{1'b0}};
      oversize_err_r <= 1'b0;
    end else begin
      oversize_err_r <= trunc_s;
      case (state_r)
        ST_IDLE: begin
          idx_r  <= {IDX_W{1'b0}};
          wcnt_r <= {WCNT_W{1'b0}};
          if (grant_take_s) begin
            grant_r <= gnt_idx_s;
          end
        end
        ST_CTRL: begin
          if (ctrl_beat_s) begin
            idx_r <= idx_r + IDX_ONE;
          end
        end
        ST_DATA: begin
          if (data_beat_s) begin
            wcnt_r <= wcnt_r + WCNT_ONE;
          end
          if (frame_end_s) begin
            last_grant_r <= grant_r;
            if (grant_r) begin
              frame_cnt1_r <= frame_cnt1_r + CNT_ONE;
            end else begin
              frame_cnt0_r <= frame_cnt0_r + CNT_ONE;
            end
          end
        end
        ST_DROP: begin
          // A truncated frame still consumed its turn, so round-robin moves on.
          if (drop_end_s) begin
            last_grant_r <= grant_r;
          end
        end
        default: begin
          idx_r <= {IDX_W{1'b0}};
        end
      endcase
    end
  end

  assign busy         = (state_r != ST_IDLE);
  assign grant        = grant_r;
  assign oversize_err = oversize_err_r;
  assign frame_cnt0   = frame_cnt0_r;
  assign frame_cnt1   = frame_cnt1_r;

endmodule
